// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, next-PC prediction and instruction queue.
// Optional dynamic branch predictor enabled by `define IFETCH_BHT_EN.
module ifetch_unit #(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        if2ctrl_en,
  output logic [31:0] next_PC,
  input  logic        inst_rdy,
  input  logic [31:0] inst_out,
  input  logic        iq_pop,
  output logic        iq_empty,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_is_c,
  output logic        iq_pred_taken,
  input  logic        bht_upd_en,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(IQ_DEPTH);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic en_q, en_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;

  logic [31:0] inst_q [IQ_DEPTH];
  logic [31:0] ipc_q  [IQ_DEPTH];
  logic        isc_q  [IQ_DEPTH];
  logic        prd_q  [IQ_DEPTH];

  logic [6:0]  opc;
  logic [31:0] jimm, bimm, pred_pc;
  logic        is_c, pred_tk, br_tk;

  assign opc  = inst_out[6:0];
  assign is_c = inst_out[1:0] != 2'b11;
  assign jimm = {{11{inst_out[31]}}, inst_out[31], inst_out[19:12],
                 inst_out[20], inst_out[30:21], 1'b0};
  assign bimm = {{19{inst_out[31]}}, inst_out[31], inst_out[7],
                 inst_out[30:25], inst_out[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
  logic [1:0] bht_q [2**BHT_BITS];
  logic [BHT_BITS-1:0] upd_idx;
  logic bht_unused;

  assign upd_idx    = bht_upd_pc[BHT_BITS:1];
  assign br_tk      = bht_q[pc_q[BHT_BITS:1]][1];
  assign bht_unused = ^{bht_upd_pc[31:BHT_BITS+1], bht_upd_pc[0]};

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2**BHT_BITS; i++) bht_q[i] <= 2'b01;
    end else if (rdy_in && bht_upd_en) begin
      if (bht_upd_taken && bht_q[upd_idx] != 2'b11)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      else if (!bht_upd_taken && bht_q[upd_idx] != 2'b00)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
    end
  end
`else
  logic bht_unused;
  // Static rule: backward branches (negative offset) are taken.
  assign br_tk      = inst_out[31];
  assign bht_unused = ^{bht_upd_en, bht_upd_pc, bht_upd_taken};
`endif

  always_comb begin
    pred_pc = pc_q + 32'd4;
    pred_tk = 1'b0;
    unique case (1'b1)
      is_c: pred_pc = pc_q + 32'd2;
      (opc == 7'b1101111): begin
        pred_pc = pc_q + jimm;
        pred_tk = 1'b1;
      end
      (opc == 7'b1100011 && br_tk): begin
        pred_pc = pc_q + bimm;
        pred_tk = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    en_d    = en_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (rdy_in) begin
      if (flush) begin
        pc_d    = flush_pc;
        state_d = IDLE;
        en_d    = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        cnt_d   = '0;
      end else begin
        pop = iq_pop && (cnt_q != '0);
        unique case (state_q)
          IDLE: if (cnt_q < DEPTH_C) begin
            en_d    = 1'b1;
            npc_d   = pc_q;
            state_d = WAIT;
          end
          WAIT: if (inst_rdy) begin
            push    = 1'b1;
            pc_d    = pred_pc;
            en_d    = 1'b0;
            state_d = IDLE;
          end
        endcase
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + (AW+1)'(1);
          2'b01:   cnt_d = cnt_q - (AW+1)'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= '0;
      en_q    <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        inst_q[i] <= '0;
        ipc_q[i]  <= '0;
        isc_q[i]  <= 1'b0;
        prd_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      en_q    <= en_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      if (push) begin
        inst_q[tail_q] <= inst_out;
        ipc_q[tail_q]  <= npc_q;
        isc_q[tail_q]  <= is_c;
        prd_q[tail_q]  <= pred_tk;
      end
    end
  end

  assign if2ctrl_en    = en_q;
  assign next_PC       = npc_q;
  assign iq_empty      = cnt_q == '0;
  assign iq_inst       = inst_q[head_q];
  assign iq_pc         = ipc_q[head_q];
  assign iq_is_c       = isc_q[head_q];
  assign iq_pred_taken = prd_q[head_q];
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table plus queue-full,
// flush and same-cycle push/pop sequences.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        if2ctrl_en;
  logic [31:0] next_PC;
  logic        inst_rdy = 1'b0;
  logic [31:0] inst_out = '0;
  logic        iq_pop = 1'b0;
  logic        iq_empty;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_is_c;
  logic        iq_pred_taken;
  logic        bht_upd_en = 1'b0;
  logic [31:0] bht_upd_pc = '0;
  logic        bht_upd_taken = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  ifetch_unit dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush(flush), .flush_pc(flush_pc),
    .if2ctrl_en(if2ctrl_en), .next_PC(next_PC),
    .inst_rdy(inst_rdy), .inst_out(inst_out),
    .iq_pop(iq_pop), .iq_empty(iq_empty),
    .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_is_c(iq_is_c), .iq_pred_taken(iq_pred_taken),
    .bht_upd_en(bht_upd_en), .bht_upd_pc(bht_upd_pc),
    .bht_upd_taken(bht_upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    logic        pred;
    logic [31:0] nxt;
  } vec_t;

  vec_t tv [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp);
    int n;
    n = 0;
    while (!if2ctrl_en && n < 20) begin
      tick();
      n++;
    end
    if (!if2ctrl_en) begin
      n_tot++;
      $display("FAIL %s: no request within 20 cycles, expected %h",
               nm, exp);
    end else begin
      chk(nm, next_PC, exp);
    end
  endtask

  task automatic serve(input logic [31:0] inst, input logic pop);
    inst_rdy = 1'b1;
    inst_out = inst;
    iq_pop   = pop;
    tick();
    inst_rdy = 1'b0;
    inst_out = '0;
    iq_pop   = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] fpc);
    flush    = 1'b1;
    flush_pc = fpc;
    tick();
    flush    = 1'b0;
  endtask

  task automatic pop1;
    iq_pop = 1'b1;
    tick();
    iq_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    tv[0] = '{1'b0, 32'h0, 32'h00000013, 32'h0, 1'b0, 1'b0, 32'h4};
    tv[1] = '{1'b0, 32'h0, 32'h00000013, 32'h4, 1'b0, 1'b0, 32'h8};
    tv[2] = '{1'b0, 32'h0, 32'h00000013, 32'h8, 1'b0, 1'b0, 32'hC};
    tv[3] = '{1'b1, 32'h10, 32'h00004501, 32'h10, 1'b1, 1'b0, 32'h12};
    tv[4] = '{1'b1, 32'h20, 32'h0100006F, 32'h20, 1'b0, 1'b1, 32'h30};
`ifdef IFETCH_BHT_EN
    tv[5] = '{1'b1, 32'h40, 32'hFE000EE3, 32'h40, 1'b0, 1'b0, 32'h44};
`else
    tv[5] = '{1'b1, 32'h40, 32'hFE000EE3, 32'h40, 1'b0, 1'b1, 32'h3C};
`endif
    tv[6] = '{1'b1, 32'h50, 32'h000080E7, 32'h50, 1'b0, 1'b0, 32'h54};
    tv[7] = '{1'b1, 32'h60, 32'h00000463, 32'h60, 1'b0, 1'b0, 32'h64};
    tv[8] = '{1'b1, 32'hFFFFFFFE, 32'h00004501, 32'hFFFFFFFE,
              1'b1, 1'b0, 32'h0};

    #1 rst_in = 1'b1;
    #2;
    chk("rst_en", {31'b0, if2ctrl_en}, 32'h0);
    chk("rst_npc", next_PC, 32'h0);
    chk("rst_empty", {31'b0, iq_empty}, 32'h1);
    chk("rst_inst", iq_inst, 32'h0);
    chk("rst_pc", iq_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (tv[i].fl) do_flush(tv[i].fpc);
      wait_req($sformatf("v%0d_req", i), tv[i].pc);
      serve(tv[i].inst, 1'b0);
      chk($sformatf("v%0d_nempty", i), {31'b0, iq_empty}, 32'h0);
      chk($sformatf("v%0d_inst", i), iq_inst, tv[i].inst);
      chk($sformatf("v%0d_pc", i), iq_pc, tv[i].pc);
      chk($sformatf("v%0d_isc", i), {31'b0, iq_is_c}, {31'b0, tv[i].is_c});
      chk($sformatf("v%0d_pred", i), {31'b0, iq_pred_taken},
          {31'b0, tv[i].pred});
      pop1();
      chk($sformatf("v%0d_empty", i), {31'b0, iq_empty}, 32'h1);
      wait_req($sformatf("v%0d_next", i), tv[i].nxt);
    end

`ifdef IFETCH_BHT_EN
    do_flush(32'h40);
    wait_req("bht_req", 32'h40);
    bht_upd_en    = 1'b1;
    bht_upd_pc    = 32'h40;
    bht_upd_taken = 1'b1;
    tick();
    tick();
    bht_upd_en = 1'b0;
    serve(32'hFE000EE3, 1'b0);
    chk("bht_pred", {31'b0, iq_pred_taken}, 32'h1);
    pop1();
    wait_req("bht_next", 32'h3C);
`endif

    do_flush(32'h300);
    for (int k = 0; k < 8; k++) begin
      wait_req($sformatf("fill%0d", k), 32'h300 + 32'(4 * k));
      serve(32'h00000013, 1'b0);
    end
    hi = 0;
    repeat (6) begin
      tick();
      if (if2ctrl_en) hi++;
    end
    chk("full_stall", 32'(hi), 32'h0);
    chk("full_head", iq_pc, 32'h300);
    pop1();
    wait_req("refill_req", 32'h320);
    chk("refill_head", iq_pc, 32'h304);
    serve(32'h00000013, 1'b0);
    hi = 0;
    repeat (6) begin
      tick();
      if (if2ctrl_en) hi++;
    end
    chk("refull_stall", 32'(hi), 32'h0);

    do_flush(32'h500);
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("f3_%0d", k), 32'h500 + 32'(4 * k));
      serve(32'h00000013, 1'b0);
    end
    wait_req("f3_wait", 32'h50C);
    chk("f3_head", iq_pc, 32'h500);
    do_flush(32'h100);
    chk("flush_empty", {31'b0, iq_empty}, 32'h1);
    chk("flush_en", {31'b0, if2ctrl_en}, 32'h0);
    wait_req("flush_req", 32'h100);
    chk("flush_nostale", {31'b0, iq_empty}, 32'h1);
    serve(32'h00000013, 1'b0);
    wait_req("pp_req", 32'h104);
    serve(32'h00000013, 1'b1);
    chk("pp_head", iq_pc, 32'h104);
    chk("pp_nempty", {31'b0, iq_empty}, 32'h0);

    rdy_in = 1'b0;
    pop1();
    chk("frz_head", iq_pc, 32'h104);
    chk("frz_en", {31'b0, if2ctrl_en}, 32'h0);
    rdy_in = 1'b1;
    pop1();
    chk("pop_empty", {31'b0, iq_empty}, 32'h1);
    pop1();
    chk("pop_on_empty", {31'b0, iq_empty}, 32'h1);
    wait_req("after_req", 32'h108);
    serve(32'h00000013, 1'b0);
    chk("after_head", iq_pc, 32'h108);
    pop1();
    chk("after_empty", {31'b0, iq_empty}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
